writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
Single-write-port writeback stage directly upstream of the 16x16 register file. It arbitrates ALU results and load-return data onto the regfile's one write port (wr_en/wr_addr/wr_data), registered. It keeps a pending-load scoreboard so decode can detect RAW hazards. It also forwards the in-flight write to the regfile's asynchronous read ports.

Parameters:
DATA_W, 16, data width; matches regfile word.
ADDR_W, 4, register address width.
NREGS, 16, architectural registers; index NREGS-1 (r15) is PC-mapped and read-only.
STARVE_LIM, 2, maximum consecutive load grants while ALU waits.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle
alu_dest  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
ld_issue  in  1  load issued to memory (marks dest pending)
ld_issue_dest  in  ADDR_W  destination of issued load
ld_valid  in  1  load data returning
ld_ready  out  1  load return accepted this cycle
ld_dest  in  ADDR_W  load-return destination
ld_data  in  DATA_W  load-return data
rd_addr_0, rd_addr_1  in  ADDR_W  decode read addresses (same as regfile)
hazard_0, hazard_1  out  1  read address has an outstanding load
fwd_0, fwd_1  out  1  read address matches the write being committed this cycle
fwd_data  out  DATA_W  data of the write being committed (equals wr_data)
wr_en  out  1  regfile write enable
wr_addr  out  ADDR_W  regfile write address
wr_data  out  DATA_W  regfile write data
pending  out  NREGS  scoreboard bit-vector
sb_err  out  1  sticky: load returned to a non-pending register

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, pending=0, sb_err=0, starve count=0. alu_ready and ld_ready are 0 during the reset cycle.
- Handshake: a transfer occurs when valid&&ready in the same cycle. Ready outputs are combinational from the valids and the arbiter state. Ready never depends on the source's own data.
- Arbitration, one grant per cycle:
  - Only one source valid: that source is granted.
  - Both valid: load wins, unless starve_cnt==STARVE_LIM, in which case ALU wins.
  - starve_cnt increments on a load grant while alu_valid is high. It clears on any ALU grant, and when alu_valid is low. It saturates at STARVE_LIM.
- Write latency is one cycle. The granted transfer in cycle N drives wr_en=1, wr_addr=dest, wr_data=data as registered outputs in cycle N+1. The regfile then commits at the end of N+1.
- No grant in cycle N drives wr_en=0 in N+1; wr_addr/wr_data hold their previous values.
- Dest==NREGS-1 (r15): the transfer is accepted (ready=1) but wr_en stays 0 in N+1. For a load, the pending bit is still cleared.
- Scoreboard:
  - ld_issue sets pending[ld_issue_dest].
  - An accepted load return clears pending[ld_dest] at the same edge as the grant.
  - Same register set and cleared in one cycle: set wins, bit stays 1.
  - ld_issue to r15 is ignored.
  - An accepted load return with pending[ld_dest]==0 sets sb_err (sticky until reset). The data is still written.
- Hazard: hazard_k = pending[rd_addr_k], combinational. It is always 0 for rd_addr_k==15.
- Forwarding:
  - fwd_k = wr_en && wr_addr==rd_addr_k && rd_addr_k!=15, combinational from the registered write.
  - The regfile read returns the old value in that cycle, so decode uses fwd_data when fwd_k is set.
- ALU write to a register with pending=1 (WAW) is not checked here; decode prevents it.
- Reset mid-operation: all state clears; any transfer presented in the reset cycle is dropped (ready=0).

Decomposition:
- Shared package (core_pkg): DATA_W, ADDR_W, NREGS, PC_REG=4'd15, and a wb_req_t struct {dest, data}.
- One natural sub-module, wb_scoreboard: the pending vector, set/clear priority, sb_err, and the hazard lookups.
- Arbiter, output register and forwarding stay in the top module.

Test Plan:
1. Reset, then alu_valid=1, dest=3, data=16'h1234 in cycle 0 -> alu_ready=1 in cycle 0; wr_en=1, wr_addr=3, wr_data=16'h1234 in cycle 1; wr_en=0 in cycle 2.
2. ld_issue dest=5 -> pending[5]=1 and hazard_0=1 for rd_addr_0=5. Then ld_valid dest=5, data=16'hBEEF -> pending[5]=0 on the next cycle, wr_en=1 with 16'hBEEF, sb_err=0.
3. Both valid for 4 cycles (STARVE_LIM=2), ALU dest=1, load dest=2 with 3 returns pending -> grants in order load, load, ALU, load.
4. Write to r15 from ALU -> alu_ready=1, wr_en stays 0, hazard/fwd stay 0 for rd_addr=15.
5. Load return to dest=7 with pending[7]=0 -> write occurs and sb_err=1 until reset. ld_issue dest=6 and return dest=6 in the same cycle -> pending[6] stays 1.
6. Write committing dest=9, data=16'h00A5 with rd_addr_1=9 -> fwd_1=1, fwd_data=16'h00A5; reset asserted alongside alu_valid -> alu_ready=0, wr_en=0 next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared widths and types for the writeback stage and the register file.
//   DATA_W     : register file word width
//   ADDR_W     : register address width
//   NREGS      : number of architectural registers (last one is PC-mapped)
//   STARVE_LIM : maximum back-to-back load grants while an ALU result waits
//   PC_REG     : index of the read-only PC-mapped register
//   wb_req_t   : one writeback request (destination register + data)
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;
    localparam int NREGS      = 16;
    localparam int STARVE_LIM = 2;

    // Counter must be able to hold the value STARVE_LIM itself.
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);

    localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(NREGS - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// ----------------------------------------------------------------------------
// wb_scoreboard
// Pending-load scoreboard: one bit per register marking an outstanding load.
//   clk, reset        : clock, synchronous active-high reset
//   ld_issue          : a load was issued this cycle
//   ld_issue_dest     : destination of the issued load (PC register ignored)
//   ld_ret            : a load return was accepted this cycle
//   ld_ret_dest       : destination of the accepted load return
//   rd_addr_0/1       : decode read addresses
//   hazard_0/1        : read address has an outstanding load
//   pending           : full scoreboard vector
//   sb_err            : sticky flag, a load returned to a non-pending register
// ----------------------------------------------------------------------------
module wb_scoreboard
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_dest,
    input  logic              ld_ret,
    input  logic [ADDR_W-1:0] ld_ret_dest,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic              hazard_0,
    output logic              hazard_1,
    output logic [NREGS-1:0]  pending,
    output logic              sb_err
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic             sb_err_q, sb_err_d;

    // Clear is applied before set so that an issue and a return to the same
    // register in one cycle leave the register pending (the new load wins).
    always_comb begin
        pending_d = pending_q;
        sb_err_d  = sb_err_q;
        if (ld_ret) begin
            pending_d[ld_ret_dest] = 1'b0;
            if (!pending_q[ld_ret_dest]) begin
                sb_err_d = 1'b1;
            end
        end
        if (ld_issue && (ld_issue_dest != PC_REG)) begin
            pending_d[ld_issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            sb_err_q  <= sb_err_d;
        end
    end

    // The PC register can never carry a hazard.
    assign hazard_0 = pending_q[rd_addr_0] && (rd_addr_0 != PC_REG);
    assign hazard_1 = pending_q[rd_addr_1] && (rd_addr_1 != PC_REG);
    assign pending  = pending_q;
    assign sb_err   = sb_err_q;

endmodule

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
// Arbitrates ALU results and load returns onto the single register file
// write port, registers the winning write, tracks pending loads and forwards
// the write being committed to the decode read ports.
//   clk, reset              : clock, synchronous active-high reset
//   alu_valid/ready/dest/data : ALU result channel
//   ld_issue, ld_issue_dest : load issue (marks destination pending)
//   ld_valid/ready/dest/data  : load return channel
//   rd_addr_0/1             : decode read addresses
//   hazard_0/1              : read address has an outstanding load
//   fwd_0/1, fwd_data       : read address matches the committing write
//   wr_en/addr/data         : registered register file write port
//   pending, sb_err         : scoreboard vector and sticky error flag
// ----------------------------------------------------------------------------
module writeback_arbiter
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_dest,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic              hazard_0,
    output logic              hazard_1,
    output logic              fwd_0,
    output logic              fwd_1,
    output logic [DATA_W-1:0] fwd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREGS-1:0]  pending,
    output logic              sb_err
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic    starved;
    logic    alu_gnt;
    logic    ld_gnt;
    wb_req_t gnt_req;

    assign starved = (starve_q == STARVE_MAX);

    // Loads normally win because the memory pipe cannot stall; once the ALU
    // has waited STARVE_LIM load grants it takes the port. Nothing is granted
    // while reset is high so transfers offered then are dropped.
    always_comb begin
        ld_gnt  = 1'b0;
        alu_gnt = 1'b0;
        gnt_req = '0;
        if (!reset) begin
            ld_gnt  = ld_valid && !(alu_valid && starved);
            alu_gnt = alu_valid && !ld_gnt;
        end
        if (ld_gnt) begin
            gnt_req = '{dest: ld_dest, data: ld_data};
        end else if (alu_gnt) begin
            gnt_req = '{dest: alu_dest, data: alu_data};
        end
    end

    // Starvation counter only counts loads that beat a waiting ALU result.
    // A write to the PC register is accepted but never reaches the port, and
    // address/data hold so the forwarding path keeps the last real write.
    always_comb begin
        starve_d  = starve_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (alu_gnt || !alu_valid) begin
            starve_d = '0;
        end else if (ld_gnt && !starved) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        if ((alu_gnt || ld_gnt) && (gnt_req.dest != PC_REG)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = gnt_req.dest;
            wr_data_d = gnt_req.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .ld_issue      (ld_issue),
        .ld_issue_dest (ld_issue_dest),
        .ld_ret        (ld_gnt),
        .ld_ret_dest   (ld_dest),
        .rd_addr_0     (rd_addr_0),
        .rd_addr_1     (rd_addr_1),
        .hazard_0      (hazard_0),
        .hazard_1      (hazard_1),
        .pending       (pending),
        .sb_err        (sb_err)
    );

    // The register file returns the old value while a write is committing,
    // so decode must take the in-flight data instead.
    assign fwd_0    = wr_en_q && (wr_addr_q == rd_addr_0) && (rd_addr_0 != PC_REG);
    assign fwd_1    = wr_en_q && (wr_addr_q == rd_addr_1) && (rd_addr_1 != PC_REG);
    assign fwd_data = wr_data_q;

    assign alu_ready = alu_gnt;
    assign ld_ready  = ld_gnt;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the writeback stage kept in this file.
// ----------------------------------------------------------------------------
module tb_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_dest;
    logic [15:0] alu_data;
    logic        ld_issue;
    logic [3:0]  ld_issue_dest;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_dest;
    logic [15:0] ld_data;
    logic [3:0]  rd_addr_0;
    logic [3:0]  rd_addr_1;
    logic        hazard_0;
    logic        hazard_1;
    logic        fwd_0;
    logic        fwd_1;
    logic [15:0] fwd_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] pending;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [15:0] m_pending;
    int        m_starve;
    bit        m_sb_err;
    bit        m_wr_en;
    bit [3:0]  m_wr_addr;
    bit [15:0] m_wr_data;

    // Ready values seen during the most recent stimulus cycle
    logic obs_alu_ready;
    logic obs_ld_ready;

    writeback_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_dest      (alu_dest),
        .alu_data      (alu_data),
        .ld_issue      (ld_issue),
        .ld_issue_dest (ld_issue_dest),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_dest       (ld_dest),
        .ld_data       (ld_data),
        .rd_addr_0     (rd_addr_0),
        .rd_addr_1     (rd_addr_1),
        .hazard_0      (hazard_0),
        .hazard_1      (hazard_1),
        .fwd_0         (fwd_0),
        .fwd_1         (fwd_1),
        .fwd_data      (fwd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .pending       (pending),
        .sb_err        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge, checks the
    // combinational outputs half a cycle later, then checks the registered
    // outputs just after the next rising edge.
    task automatic applyStimulus(input logic rst,
                                 input logic av, input logic [3:0] ad, input logic [15:0] adat,
                                 input logic li, input logic [3:0] lid,
                                 input logic lv, input logic [3:0] ldd, input logic [15:0] ldat,
                                 input logic [3:0] r0, input logic [3:0] r1);
        bit        e_ld_gnt;
        bit        e_alu_gnt;
        bit [3:0]  g_dest;
        bit [15:0] g_data;
        bit [15:0] nxt_pend;

        reset         = rst;
        alu_valid     = av;
        alu_dest      = ad;
        alu_data      = adat;
        ld_issue      = li;
        ld_issue_dest = lid;
        ld_valid      = lv;
        ld_dest       = ldd;
        ld_data       = ldat;
        rd_addr_0     = r0;
        rd_addr_1     = r1;
        #4;

        e_ld_gnt  = !rst && lv && !(av && m_starve == 2);
        e_alu_gnt = !rst && av && !e_ld_gnt;
        obs_alu_ready = alu_ready;
        obs_ld_ready  = ld_ready;
        checkOutput("alu_ready", alu_ready, e_alu_gnt);
        checkOutput("ld_ready", ld_ready, e_ld_gnt);
        checkOutput("hazard_0", hazard_0, (r0 != 4'd15) && m_pending[r0]);
        checkOutput("hazard_1", hazard_1, (r1 != 4'd15) && m_pending[r1]);
        checkOutput("fwd_0", fwd_0, m_wr_en && (m_wr_addr == r0) && (r0 != 4'd15));
        checkOutput("fwd_1", fwd_1, m_wr_en && (m_wr_addr == r1) && (r1 != 4'd15));
        checkOutput("fwd_data", fwd_data, m_wr_data);

        @(posedge clk);
        #1;

        if (rst) begin
            m_pending = '0;
            m_starve  = 0;
            m_sb_err  = 1'b0;
            m_wr_en   = 1'b0;
            m_wr_addr = '0;
            m_wr_data = '0;
        end else begin
            nxt_pend = m_pending;
            if (e_ld_gnt) begin
                if (!m_pending[ldd]) m_sb_err = 1'b1;
                nxt_pend[ldd] = 1'b0;
            end
            if (li && lid != 4'd15) nxt_pend[lid] = 1'b1;
            m_pending = nxt_pend;

            if (e_alu_gnt || !av) m_starve = 0;
            else if (e_ld_gnt && m_starve < 2) m_starve++;

            g_dest = e_ld_gnt ? ldd : ad;
            g_data = e_ld_gnt ? ldat : adat;
            m_wr_en = (e_ld_gnt || e_alu_gnt) && (g_dest != 4'd15);
            if (m_wr_en) begin
                m_wr_addr = g_dest;
                m_wr_data = g_data;
            end
        end

        checkOutput("wr_en", wr_en, m_wr_en);
        checkOutput("wr_addr", wr_addr, m_wr_addr);
        checkOutput("wr_data", wr_data, m_wr_data);
        checkOutput("pending", pending, m_pending);
        checkOutput("sb_err", sb_err, m_sb_err);
    endtask

    initial begin
        m_pending = '0;
        m_starve  = 0;
        m_sb_err  = 1'b0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        reset = 1'b1;
        alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_dest = '0;
        ld_valid = 1'b0; ld_dest = '0; ld_data = '0;
        rd_addr_0 = '0; rd_addr_1 = '0;
        @(posedge clk);
        #1;

        // Reset cycle
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_wr_en", wr_en, 1'b0);
        checkOutput("reset_pending", pending, 16'h0000);

        // Single ALU write, then idle
        applyStimulus(0, 1, 4'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_alu_ready", obs_alu_ready, 1'b1);
        checkOutput("t1_wr_addr", wr_addr, 4'd3);
        checkOutput("t1_wr_data", wr_data, 16'h1234);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_wr_en_idle", wr_en, 1'b0);

        // Load issue then return
        applyStimulus(0, 0, 0, 0, 1, 4'd5, 0, 0, 0, 0, 0);
        checkOutput("t2_pending5", pending[5], 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd5, 16'hBEEF, 4'd5, 0);
        checkOutput("t2_pending5_clr", pending[5], 1'b0);
        checkOutput("t2_wr_data", wr_data, 16'hBEEF);
        checkOutput("t2_sb_err", sb_err, 1'b0);

        // Starvation limit: expected grant order load, load, ALU, load
        applyStimulus(0, 0, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 4'd1, 16'h1111, 0, 0, 1, 4'd2, 16'h2222, 0, 0);
        checkOutput("t3_g0_ld", obs_ld_ready, 1'b1);
        applyStimulus(0, 1, 4'd1, 16'h1111, 0, 0, 1, 4'd2, 16'h2223, 0, 0);
        checkOutput("t3_g1_ld", obs_ld_ready, 1'b1);
        applyStimulus(0, 1, 4'd1, 16'h1111, 0, 0, 1, 4'd2, 16'h2224, 0, 0);
        checkOutput("t3_g2_alu", obs_alu_ready, 1'b1);
        checkOutput("t3_g2_wr_addr", wr_addr, 4'd1);
        applyStimulus(0, 1, 4'd1, 16'h1112, 0, 0, 1, 4'd2, 16'h2224, 0, 0);
        checkOutput("t3_g3_ld", obs_ld_ready, 1'b1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Write to the PC register
        applyStimulus(0, 1, 4'd15, 16'hCAFE, 1, 4'd15, 0, 0, 0, 4'd15, 4'd15);
        checkOutput("t4_alu_ready", obs_alu_ready, 1'b1);
        checkOutput("t4_wr_en", wr_en, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd15, 4'd15);
        checkOutput("t4_hazard", hazard_0, 1'b0);
        checkOutput("t4_fwd", fwd_1, 1'b0);

        // Unexpected load return, then same-cycle issue and return
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd7, 16'h0777, 0, 0);
        checkOutput("t5_wr_en", wr_en, 1'b1);
        checkOutput("t5_sb_err", sb_err, 1'b1);
        applyStimulus(0, 0, 0, 0, 1, 4'd6, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 4'd6, 1, 4'd6, 16'h0666, 0, 0);
        checkOutput("t5_pending6", pending[6], 1'b1);
        checkOutput("t5_sb_err_sticky", sb_err, 1'b1);

        // Forwarding and reset alongside a valid ALU result
        applyStimulus(0, 1, 4'd9, 16'h00A5, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 4'd4, 16'h4444, 0, 0, 0, 0, 0, 4'd3, 4'd9);
        checkOutput("t6_reset_alu_ready", obs_alu_ready, 1'b0);
        checkOutput("t6_reset_wr_en", wr_en, 1'b0);
        checkOutput("t6_reset_sb_err", sb_err, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
